dot_stream_mac: RTL and testbench

//  Streaming, parametrised dot-product engine: y = sum(x[i]*h[i]), i = 0..len-1.
//  - Element pairs arrive one per cycle over a valid/ready handshake.
//  - Vector length is chosen per operation at start; signed or unsigned mode is set at build time.
//  - The result is held under its own valid/ready handshake.
//  - Sits between the sample/coefficient stream sources and downstream filter/accumulate logic.
//  - Supersedes the fixed 10-tap, 4-bit, single-cycle dot-product block.

---
 rtl/dot_pkg.sv | 16 +
 rtl/dot_mul_stage.sv | 46 ++++
 rtl/dot_stream_mac.sv | 128 ++++++++++++
 tb/tb_dot_stream_mac.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared types and width helpers for the streaming dot-product engine.
package dot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Accumulator width that cannot wrap for n_max products of two dw-bit operands.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n_max);
    return 2 * dw + $clog2(n_max);
  endfunction

endpackage

// File: rtl/dot_mul_stage.sv
// Registered x*h multiplier (pipeline stage 1) with a qualifying valid bit.
module dot_mul_stage #(
  parameter int unsigned DW     = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [DW-1:0]   x_i,
  input  logic [DW-1:0]   h_i,
  output logic            valid_o,
  output logic [2*DW-1:0] prod_o
);

  localparam int unsigned PW = 2 * DW;

  logic [PW-1:0] prod_d;
  logic [PW-1:0] prod_q;
  logic          valid_q;

  if (SIGNED) begin : g_signed
    logic signed [PW-1:0] xs;
    logic signed [PW-1:0] hs;
    always_comb begin
      xs     = PW'($signed(x_i));
      hs     = PW'($signed(h_i));
      prod_d = PW'(xs * hs);
    end
  end else begin : g_unsigned
    always_comb prod_d = PW'(x_i) * PW'(h_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      prod_q  <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) prod_q <= prod_d;
    end
  end

  assign valid_o = valid_q;
  assign prod_o  = prod_q;

endmodule

// File: rtl/dot_stream_mac.sv
// Streaming dot-product engine: accepts one x/h pair per cycle and returns
// sum(x*h) under a valid/ready result handshake.
module dot_stream_mac
  import dot_pkg::*;
#(
  parameter int unsigned DW     = 4,
  parameter int unsigned N_MAX  = 10,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned LW     = $clog2(N_MAX + 1),
  parameter int unsigned AW     = acc_width(DW, N_MAX)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_x,
  input  logic [DW-1:0] in_h,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_y,
  output logic          busy
);

  localparam int unsigned PW = 2 * DW;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] out_y_q, out_y_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic          in_xfer_c;
  logic [LW-1:0] len_clamped_c;
  logic          prod_valid;
  logic [PW-1:0] prod;
  logic [AW-1:0] prod_ext;

  assign in_xfer_c     = in_valid & in_ready_q;
  assign len_clamped_c = (len > LW'(N_MAX)) ? LW'(N_MAX) : len;

  dot_mul_stage #(
    .DW     (DW),
    .SIGNED (SIGNED)
  ) u_mul (
    .clk     (clk),
    .rst_n   (reset_n),
    .valid_i (in_xfer_c),
    .x_i     (in_x),
    .h_i     (in_h),
    .valid_o (prod_valid),
    .prod_o  (prod)
  );

  if (SIGNED) begin : g_ext_signed
    assign prod_ext = AW'($signed(prod));
  end else begin : g_ext_unsigned
    assign prod_ext = AW'(prod);
  end

  // Next state; the accumulator (stage 2) folds in whatever stage 1 registered last cycle.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = prod_valid ? acc_q + prod_ext : acc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          if (len_clamped_c == '0) begin
            state_d = DONE;
          end else begin
            len_d   = len_clamped_c;
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (in_xfer_c) begin
          cnt_d = cnt_q + LW'(1);
          if (cnt_q == len_q - LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    out_y_d     = ((state_d == DONE) && (state_q != DONE)) ? acc_d : out_y_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_y_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_y_q     <= out_y_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dot_stream_mac.sv
// Bench for dot_stream_mac: unsigned and signed builds driven side by side.
module tb_dot_stream_mac;

  localparam int unsigned DW    = 4;
  localparam int unsigned N_MAX = 10;
  localparam int unsigned LW    = 4;
  localparam int unsigned AW    = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [LW-1:0] len;
  logic          in_valid;
  logic [DW-1:0] in_x, in_h;
  logic          out_ready;

  logic          in_ready_u, out_valid_u, busy_u;
  logic [AW-1:0] out_y_u;
  logic          in_ready_s, out_valid_s, busy_s;
  logic [AW-1:0] out_y_s;

  always #5 clk = ~clk;

  dot_stream_mac #(.DW(DW), .N_MAX(N_MAX), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_x(in_x), .in_h(in_h),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_y(out_y_u), .busy(busy_u)
  );

  dot_stream_mac #(.DW(DW), .N_MAX(N_MAX), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_x(in_x), .in_h(in_h),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_y(out_y_s), .busy(busy_s)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string         name;
    int            n;
    logic [39:0]   xv;
    logic [39:0]   hv;
    int            gaps;      // 0 steady, 1 alternate, 2 random (also random out_ready while loading)
    int            hold;      // cycles out_ready stays low in DONE
    bit            poke;      // pulse start during LOAD
    bit            start_ack; // raise start together with out_ready
    logic [AW-1:0] exp_u;
    logic [AW-1:0] exp_s;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain-arithmetic dot product over the clamped length.
  function automatic logic [AW-1:0] model(input int n, input logic [39:0] xv,
                                          input logic [39:0] hv, input bit sgn);
    int acc = 0;
    int m   = (n > int'(N_MAX)) ? int'(N_MAX) : n;
    for (int i = 0; i < m; i++) begin
      logic [3:0] a = xv[4*i +: 4];
      logic [3:0] b = hv[4*i +: 4];
      int ai = sgn ? int'($signed(a)) : int'(a);
      int bi = sgn ? int'($signed(b)) : int'(b);
      acc += ai * bi;
    end
    return AW'(acc);
  endfunction

  function automatic vec_t mk(input string name, input int n, input logic [39:0] xv,
                              input logic [39:0] hv, input int gaps, input int hold,
                              input bit poke, input bit start_ack,
                              input int exp_u, input int exp_s);
    vec_t v;
    v.name = name; v.n = n; v.xv = xv; v.hv = hv; v.gaps = gaps; v.hold = hold;
    v.poke = poke; v.start_ack = start_ack;
    v.exp_u = AW'(exp_u); v.exp_s = AW'(exp_s);
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int  m = (v.n > int'(N_MAX)) ? int'(N_MAX) : v.n;
    int  i = 0;
    int  c = 0;
    bit  xfer;
    start = 1'b1; len = LW'(v.n);
    in_valid = 1'b1; in_x = 4'hF; in_h = 4'hF;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check({v.name, " busy"}, 32'({busy_u, busy_s}), 32'b11);
    while (i < m && c < 4 * int'(N_MAX) + 8) begin
      case (v.gaps)
        1:       in_valid = (c % 2 == 0);
        2:       in_valid = ($urandom_range(0, 3) != 0);
        default: in_valid = 1'b1;
      endcase
      in_x      = v.xv[4*i +: 4];
      in_h      = v.hv[4*i +: 4];
      start     = v.poke && (c == 2);
      if (start) len = LW'(3);
      out_ready = (v.gaps == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      xfer      = in_valid && in_ready_u;
      tick();
      if (xfer) i++;
      c++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (i < m) check({v.name, " transfers"}, 32'(i), 32'(m));
    if (m > 0) begin
      check({v.name, " drain"}, 32'({in_ready_u, out_valid_u, in_ready_s, out_valid_s}), 32'b0);
      tick();
    end
    check({v.name, " out_valid"}, 32'({out_valid_u, out_valid_s}), 32'b11);
    check({v.name, " y_unsigned"}, 32'(out_y_u), 32'(v.exp_u));
    check({v.name, " y_signed"}, 32'(out_y_s), 32'(v.exp_s));
    for (int k = 0; k < v.hold; k++) begin
      in_valid = 1'b1; in_x = 4'($urandom); in_h = 4'($urandom);
      tick();
      check({v.name, " hold_valid"}, 32'({out_valid_u, out_valid_s}), 32'b11);
      check({v.name, " hold_y"}, 32'({out_y_u, out_y_s}), 32'({v.exp_u, v.exp_s}));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    start = v.start_ack; len = LW'(2);
    tick();
    out_ready = 1'b0; start = 1'b0;
    check({v.name, " release"}, 32'({out_valid_u, busy_u, out_valid_s, busy_s}), 32'b0);
    if (v.start_ack) begin
      tick();
      check({v.name, " start_ack_idle"}, 32'({busy_u, busy_s}), 32'b0);
    end
  endtask

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    reset_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_x = '0; in_h = '0; out_ready = 1'b0;

    tbl[0] = mk("ramp_x_h15", 10, 40'hA987654321, 40'hFFFFFFFFFF, 0, 0, 1'b0, 1'b0, 825, -7);
    tbl[1] = mk("all_15",     10, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 0, 0, 1'b0, 1'b0, 2250, 10);
    tbl[2] = mk("len3_gaps",   3, 40'h0000000432, 40'h0000000765, 1, 5, 1'b0, 1'b0, 56, 56);
    tbl[3] = mk("len0",        0, 40'h0,          40'h0,          0, 2, 1'b0, 1'b1, 0, 0);
    tbl[4] = mk("poke_start", 10, 40'hA987654321, 40'h1111111111, 0, 1, 1'b1, 1'b0, 55, 7);
    tbl[5] = mk("all_m8",     10, 40'h8888888888, 40'h8888888888, 0, 0, 1'b0, 1'b0, 640, 640);
    tbl[6] = mk("m8_x_7",     10, 40'h8888888888, 40'h7777777777, 0, 1, 1'b0, 1'b0, 560, -560);
    tbl[7] = mk("len_clamp",  15, 40'h1111111111, 40'h1111111111, 0, 0, 1'b0, 1'b0, 10, 10);

    tick(); tick();
    check("reset_state", 32'({in_ready_u, out_valid_u, busy_u, out_y_u}), 32'b0);
    check("reset_state_s", 32'({in_ready_s, out_valid_s, busy_s, out_y_s}), 32'b0);
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", 32'({in_ready_u, out_valid_u, busy_u}), 32'b0);

    for (int t = 0; t < 8; t++) run_op(tbl[t]);

    // Reset mid-stream discards the partial operation.
    start = 1'b1; len = LW'(10);
    tick();
    start = 1'b0; in_valid = 1'b1; in_x = 4'd3; in_h = 4'd3;
    for (int k = 0; k < 4; k++) tick();
    reset_n = 1'b0;
    #1;
    check("midreset_u", 32'({in_ready_u, out_valid_u, busy_u}), 32'b0);
    check("midreset_s", 32'({in_ready_s, out_valid_s, busy_s}), 32'b0);
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    run_op(mk("after_reset", 2, 40'h11, 40'h11, 0, 0, 1'b0, 1'b0, 2, 2));

    for (int k = 0; k < 20; k++) begin
      r.name = $sformatf("rand%0d", k);
      r.n    = $urandom_range(0, 12);
      r.xv   = 40'({$urandom(), $urandom()});
      r.hv   = 40'({$urandom(), $urandom()});
      r.gaps = 2;
      r.hold = $urandom_range(0, 3);
      r.poke = 1'($urandom_range(0, 1));
      r.start_ack = 1'($urandom_range(0, 1));
      r.exp_u = model(r.n, r.xv, r.hv, 1'b0);
      r.exp_s = model(r.n, r.xv, r.hv, 1'b1);
      run_op(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
